arq_tx_ctrl: RTL

//  Sequences the sender-side ARQ link: drains mapped OTN words from the RX FIFO (AXIS master side),

---
 rtl/arq_tx_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/arq_tx_ctrl.sv
// Sender-side ARQ controller: frames FIFO words onto the TX link and keeps a one-frame
// replay buffer that is retransmitted on NACK or ACK timeout, up to MAX_RETRY times.
module arq_tx_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FRAME_LEN   = 16,
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_fifo_tdata,
  input  logic              i_fifo_tvalid,
  output logic              o_fifo_tready,
  output logic [DATA_W-1:0] o_otn_tx_data,
  output logic              o_otn_tx_valid,
  output logic              o_otn_tx_sof,
  output logic              o_otn_tx_eof,
  input  logic              i_otn_tx_ack,
  input  logic              i_otn_tx_nack,
  input  logic              i_arq_en,
  output logic              o_retrans_req,
  output logic              o_frame_fail,
  output logic [15:0]       o_frame_cnt,
  output logic              o_busy
);

  localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK, S_RESEND} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   buf_q [FRAME_LEN];
  logic [CW-1:0]       wcnt_q, rcnt_q;
  logic [TW-1:0]       timer_q;
  logic [RW-1:0]       retry_q;
  logic                arq_mode_q;
  logic                tready_q, valid_q, sof_q, eof_q, retrans_q, fail_q, busy_q;
  logic [DATA_W-1:0]   data_q;
  logic [15:0]         frame_cnt_q;
  logic                beat, last_beat, ack_hit, retry_ev, give_up;

  always_comb begin
    beat      = (state_q == S_SEND) && i_fifo_tvalid && tready_q;
    last_beat = beat && (wcnt_q == CNT_LAST);
    ack_hit   = (state_q == S_WAIT_ACK) && i_otn_tx_ack;
    // ACK has priority over a NACK or timeout arriving in the same cycle
    retry_ev  = (state_q == S_WAIT_ACK) && !i_otn_tx_ack &&
                (i_otn_tx_nack || (timer_q == TMR_LAST));
    give_up   = retry_ev && (retry_q == RETRY_MAX);
    state_d   = state_q;
    case (state_q)
      S_IDLE:     if (i_fifo_tvalid) state_d = S_SEND;
      S_SEND:     if (last_beat) state_d = arq_mode_q ? S_WAIT_ACK : S_IDLE;
      S_WAIT_ACK: begin
        if (ack_hit)       state_d = S_IDLE;
        else if (retry_ev) state_d = give_up ? S_IDLE : S_RESEND;
      end
      S_RESEND:   if (rcnt_q == CNT_LAST) state_d = S_WAIT_ACK;
      default:    state_d = S_IDLE;
    endcase
  end

  // Replay storage carries no reset; it is always rewritten before it is read.
  always_ff @(posedge i_clk) begin
    if (beat) buf_q[wcnt_q] <= i_fifo_tdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      arq_mode_q  <= 1'b0;
      tready_q    <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      retrans_q   <= 1'b0;
      fail_q      <= 1'b0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != S_IDLE);
      tready_q  <= (state_d == S_SEND);
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      retrans_q <= 1'b0;
      fail_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          wcnt_q <= '0;
          if (i_fifo_tvalid) arq_mode_q <= i_arq_en;
        end
        S_SEND: begin
          if (beat) begin
            data_q  <= i_fifo_tdata;
            valid_q <= 1'b1;
            sof_q   <= (wcnt_q == '0);
            eof_q   <= (wcnt_q == CNT_LAST);
            wcnt_q  <= wcnt_q + CW'(1);
          end
          if (last_beat) begin
            timer_q <= '0;
            retry_q <= '0;
            if (!arq_mode_q) frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
        S_WAIT_ACK: begin
          timer_q <= timer_q + TW'(1);
          if (ack_hit) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end else if (retry_ev) begin
            if (give_up) begin
              fail_q <= 1'b1;
            end else begin
              retry_q   <= retry_q + RW'(1);
              retrans_q <= 1'b1;
              rcnt_q    <= '0;
            end
          end
        end
        S_RESEND: begin
          // The output register doubles as the synchronous read port of the buffer
          data_q  <= buf_q[rcnt_q];
          valid_q <= 1'b1;
          sof_q   <= (rcnt_q == '0);
          eof_q   <= (rcnt_q == CNT_LAST);
          rcnt_q  <= rcnt_q + CW'(1);
          if (rcnt_q == CNT_LAST) timer_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_fifo_tready  = tready_q;
  assign o_otn_tx_data  = data_q;
  assign o_otn_tx_valid = valid_q;
  assign o_otn_tx_sof   = sof_q;
  assign o_otn_tx_eof   = eof_q;
  assign o_retrans_req  = retrans_q;
  assign o_frame_fail   = fail_q;
  assign o_frame_cnt    = frame_cnt_q;
  assign o_busy         = busy_q;

endmodule
